// File: rtl/enc_pkg.sv
// Shared definitions for the instruction encoder: symbolic ops, MIPS opcode/funct
// constants (same values the control unit decodes) and the encoder state type.
package enc_pkg;

  typedef enum logic [4:0] {
    ADD     = 5'd0,
    SUB     = 5'd1,
    JR      = 5'd2,
    ORI     = 5'd3,
    LUI     = 5'd4,
    J       = 5'd5,
    JAL     = 5'd6,
    LW      = 5'd7,
    SW      = 5'd8,
    LB      = 5'd9,
    LBU     = 5'd10,
    SB      = 5'd11,
    BEQ     = 5'd12,
    BNE     = 5'd13,
    BGTZ    = 5'd14,
    BGEZALL = 5'd15,
    LI      = 5'd16,
    NOP     = 5'd17
  } enc_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } enc_state_t;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_J       = 6'h02;
  localparam logic [5:0] OPC_JAL     = 6'h03;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_BGTZ    = 6'h07;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_LB      = 6'h20;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_LBU     = 6'h24;
  localparam logic [5:0] OPC_SB      = 6'h28;
  localparam logic [5:0] OPC_SW      = 6'h2B;
  localparam logic [5:0] OPC_BGEZALL = 6'h38;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  // Primary opcode for the non-SPECIAL ops; SPECIAL-class and pseudo ops map to 0.
  function automatic logic [5:0] opcode_of(input logic [4:0] op);
    case (op)
      ORI:     return OPC_ORI;
      LUI:     return OPC_LUI;
      J:       return OPC_J;
      JAL:     return OPC_JAL;
      LW:      return OPC_LW;
      SW:      return OPC_SW;
      LB:      return OPC_LB;
      LBU:     return OPC_LBU;
      SB:      return OPC_SB;
      BEQ:     return OPC_BEQ;
      BNE:     return OPC_BNE;
      BGTZ:    return OPC_BGTZ;
      BGEZALL: return OPC_BGEZALL;
      default: return OPC_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic op plus fields -> 32-bit MIPS word and a legal flag.
// LI is expanded by the caller into LUI/ORI halves, so it never reaches here as LI.
module instr_field_pack
  import enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic [5:0] opc;

  assign opc = opcode_of(op);

  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (op)
      ADD:     word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_ADD};
      SUB:     word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SUB};
      JR:      word = {OPC_SPECIAL, rs, 15'b0, FN_JR};
      ORI, LW, SW, LB, LBU, SB, BEQ, BNE:
               word = {opc, rs, rt, imm[15:0]};
      LUI:     word = {opc, 5'b0, rt, imm[15:0]};
      BGTZ, BGEZALL:
               word = {opc, rs, 5'b0, imm[15:0]};
      J, JAL:  word = {opc, imm};
      NOP, LI: word = 32'h0;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Symbolic-to-binary instruction encoder feeding an IM write port: one-word output
// register, sequential word addresses, LI expanded into LUI + ORI when needed.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [31:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  enc_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;
  logic [4:0]        li_rt_reg;
  logic [15:0]       li_lo_reg;

  logic              accept, drain, load, li_split;
  logic [ADDR_W-1:0] load_addr;
  logic [4:0]        pk_op, pk_rs, pk_rt, pk_rd;
  logic [25:0]       pk_imm;
  logic [31:0]       pk_word;
  logic              pk_legal;

  assign drain     = out_valid && out_ready;
  assign accept    = req_valid && req_ready;
  assign li_split  = (req_op == LI) && (req_imm[31:16] != 16'h0);
  assign load      = (state_reg == IDLE) ? (accept && pk_legal) : drain;
  assign load_addr = clear ? BASE : cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && li_split) state_next = LI_LO;
      LI_LO:   if (drain)              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The packer input is steered to the pending ORI half, an LI half, or the raw request.
  always_comb begin
    req_ready = (state_reg == IDLE) && (!out_valid || out_ready);
    pk_op     = req_op;
    pk_rs     = req_rs;
    pk_rt     = req_rt;
    pk_rd     = req_rd;
    pk_imm    = req_imm[25:0];
    if (state_reg == LI_LO) begin
      pk_op  = ORI;
      pk_rs  = li_rt_reg;
      pk_rt  = li_rt_reg;
      pk_rd  = 5'd0;
      pk_imm = {10'b0, li_lo_reg};
    end else if (req_op == LI) begin
      pk_op  = li_split ? LUI : ORI;
      pk_rs  = 5'd0;
      pk_rd  = 5'd0;
      pk_imm = {10'b0, (li_split ? req_imm[31:16] : req_imm[15:0])};
    end
  end

  instr_field_pack u_pack (
    .op    (pk_op),
    .rs    (pk_rs),
    .rt    (pk_rt),
    .rd    (pk_rd),
    .imm   (pk_imm),
    .word  (pk_word),
    .legal (pk_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_word    <= 32'h0;
      out_addr    <= BASE;
      err_illegal <= 1'b0;
      cnt_reg     <= BASE;
      li_rt_reg   <= 5'd0;
      li_lo_reg   <= 16'h0;
    end else begin
      err_illegal <= (state_reg == IDLE) && accept && !pk_legal;
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= pk_word;
        out_addr  <= load_addr;
        cnt_reg   <= load_addr + ADDR_W'(1);
      end else begin
        if (drain) out_valid <= 1'b0;
        if (clear) cnt_reg   <= BASE;
      end
      if ((state_reg == IDLE) && accept && li_split) begin
        li_rt_reg <= req_rt;
        li_lo_reg <= req_imm[15:0];
      end
    end
  end

endmodule
